// File: rtl/h80bus_pkg.sv
// Shared h80 bus definitions: command encodings, master FSM states and access-size helpers.
package h80bus_pkg;

    localparam int unsigned BUS_CMD_BITS = 3;

    typedef logic [BUS_CMD_BITS-1:0] bus_cmd_t;

    // cmd[0]=1 means the responder drives data_; cmd[2:1] selects the access size
    localparam bus_cmd_t bus_cmd_write   = 3'b000;
    localparam bus_cmd_t bus_cmd_read    = 3'b001;
    localparam bus_cmd_t bus_cmd_write_w = 3'b010;
    localparam bus_cmd_t bus_cmd_read_w  = 3'b011;
    localparam bus_cmd_t bus_cmd_write_b = 3'b100;
    localparam bus_cmd_t bus_cmd_read_b  = 3'b101;

    typedef enum logic [2:0] {
        mst_idle,
        mst_t1,
        mst_t2,
        mst_wait,
        mst_done
    } h80bus_mst_state_t;

    function automatic logic is_read(input bus_cmd_t c);
        return c[0];
    endfunction

    function automatic logic [2:0] access_bytes(input bus_cmd_t c);
        case (c[2:1])
            2'b01:   return 3'd2;
            2'b10:   return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input bus_cmd_t c, input logic [1:0] a);
        case (access_bytes(c))
            3'd4:    return a != 2'b00;
            3'd2:    return a[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/h80bus_master.sv
// Initiator end of the h80 bus: one CPU request at a time, runs T1/T2/WAIT bus cycle, returns data or error.
// Optional H80BUS_TIMEOUT_EN aborts a cycle after TIMEOUT_CYCLES consecutive wait_n-low samples.
module h80bus_master
    import h80bus_pkg::*;
#(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3,
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  req_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n
);

    h80bus_mst_state_t         state, state_d;
    logic                      ce_n_d, req_ready_d, rsp_valid_d, rsp_err_d;
    logic [BUS_ADDR_WIDTH-1:0] addr_d;
    logic [BUS_CMD_WIDTH-1:0]  cmd_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_r, wdata_d, rsp_rdata_d;

`ifdef H80BUS_TIMEOUT_EN
    localparam int unsigned TO_CNT_W = 16;
    logic [TO_CNT_W-1:0] to_cnt, to_cnt_d;
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
`endif

    // Write data is only on the bus while the cycle is live; ce_n resets high so release is asynchronous
    assign data_ = (!ce_n && !is_read(bus_cmd_t'(cmd))) ? wdata_r : 'z;

    // Next-state and next-output logic; every output register is loaded from its _d value
    always_comb begin
        state_d     = state;
        ce_n_d      = ce_n;
        addr_d      = addr;
        cmd_d       = cmd;
        wdata_d     = wdata_r;
        req_ready_d = req_ready;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef H80BUS_TIMEOUT_EN
        to_cnt_d    = to_cnt;
`endif
        unique case (state)
            mst_idle: begin
                if (req_valid && req_ready) begin
                    addr_d      = req_addr;
                    cmd_d       = req_cmd;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (is_misaligned(bus_cmd_t'(req_cmd), 2'(req_addr))) begin
                        state_d     = mst_done;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = mst_t1;
                        ce_n_d  = 1'b0;
                    end
                end
            end
            mst_t1: begin
                state_d = mst_t2;
`ifdef H80BUS_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            mst_t2, mst_wait: begin
                if (wait_n) begin
                    state_d     = mst_done;
                    ce_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = is_read(bus_cmd_t'(cmd)) ? data_ : '0;
                end else begin
                    state_d = mst_wait;
`ifdef H80BUS_TIMEOUT_EN
                    to_cnt_d = to_cnt + TO_CNT_W'(1);
                    if (32'(to_cnt_d) >= TIMEOUT_CYCLES) begin
                        state_d     = mst_done;
                        ce_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
`endif
                end
            end
            mst_done: begin
                state_d     = mst_idle;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = mst_idle;
                ce_n_d      = 1'b1;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= mst_idle;
            ce_n      <= 1'b1;
            addr      <= '0;
            cmd       <= '0;
            wdata_r   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef H80BUS_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_d;
            ce_n      <= ce_n_d;
            addr      <= addr_d;
            cmd       <= cmd_d;
            wdata_r   <= wdata_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
`ifdef H80BUS_TIMEOUT_EN
            to_cnt    <= to_cnt_d;
`endif
        end
    end

endmodule
